// File: rtl/term_seq_controller.sv
// Term sequencer control FSM: steps a multiply/accumulate datapath through
// N terms of MULT_STEPS multiply cycles followed by one accumulate cycle.
// Control strobes are Moore outputs, decoded from the next state and step
// count and held in registers so every strobe leaves a flop.
module term_seq_controller #(
    parameter int MULT_STEPS = 4,
    parameter int S_SPLIT    = 2,
    parameter int TERMS      = 8,
    parameter int TW         = $clog2(TERMS + 1),
    parameter int SW         = $clog2(MULT_STEPS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [TW-1:0] nterms,
    output logic          busy,
    output logic          done,
    output logic          zx,
    output logic          zt,
    output logic          zr,
    output logic          ldx,
    output logic          initt,
    output logic          initr,
    output logic          ldt,
    output logic          ldr,
    output logic          s,
    output logic [TW-1:0] term_idx,
    output logic [SW-1:0] step_idx
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_BEGIN = 3'd2;
    localparam logic [2:0] ST_MULT  = 3'd3;
    localparam logic [2:0] ST_ADD   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [TW-1:0] TERMS_W   = TW'(TERMS);
    localparam logic [TW-1:0] TERM_ONE  = TW'(1);
    localparam logic [SW-1:0] STEP_ONE  = SW'(1);
    localparam logic [SW-1:0] STEP_LAST = SW'(MULT_STEPS - 1);
    localparam logic [SW-1:0] SPLIT_W   = SW'(S_SPLIT);

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] term_q, term_d;
    logic [SW-1:0] step_q, step_d;
    logic [TW-1:0] count_q, count_d;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic zx_q, zx_d;
    logic zt_q, zt_d;
    logic zr_q, zr_d;
    logic ldx_q, ldx_d;
    logic initt_q, initt_d;
    logic initr_q, initr_d;
    logic ldt_q, ldt_d;
    logic ldr_q, ldr_d;
    logic s_q, s_d;

    // Next-state and counter update; abort outranks every other transition outside IDLE.
    always_comb begin
        state_d = state_q;
        term_d  = term_q;
        step_d  = step_q;
        count_d = count_q;
        if ((state_q != ST_IDLE) && abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (start) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_BEGIN;
                    end
                end
                ST_BEGIN: begin
                    // Zero or oversized requests run the full term count.
                    if ((nterms == {TW{1'b0}}) || (nterms > TERMS_W)) begin
                        count_d = TERMS_W;
                    end else begin
                        count_d = nterms;
                    end
                    term_d  = {TW{1'b0}};
                    step_d  = {SW{1'b0}};
                    state_d = ST_MULT;
                end
                ST_MULT: begin
                    if (step_q == STEP_LAST) begin
                        step_d  = {SW{1'b0}};
                        state_d = ST_ADD;
                    end else begin
                        step_d  = step_q + STEP_ONE;
                        state_d = ST_MULT;
                    end
                end
                ST_ADD: begin
                    if (term_q == (count_q - TERM_ONE)) begin
                        state_d = ST_DONE;
                    end else begin
                        term_d  = term_q + TERM_ONE;
                        state_d = ST_MULT;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Moore decode of the upcoming state so the registered strobes line up with it.
    always_comb begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        zx_d    = 1'b0;
        zt_d    = 1'b0;
        zr_d    = 1'b0;
        ldx_d   = 1'b0;
        initt_d = 1'b0;
        initr_d = 1'b0;
        ldt_d   = 1'b0;
        ldr_d   = 1'b0;
        s_d     = 1'b0;
        if (state_d != ST_IDLE) begin
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
        case (state_d)
            ST_IDLE: begin
                zx_d = 1'b1;
                zt_d = 1'b1;
                zr_d = 1'b1;
            end
            ST_LOAD: begin
                ldx_d = 1'b1;
            end
            ST_BEGIN: begin
                initt_d = 1'b1;
                initr_d = 1'b1;
            end
            ST_MULT: begin
                ldt_d = 1'b1;
                if (step_d >= SPLIT_W) begin
                    s_d = 1'b1;
                end else begin
                    s_d = 1'b0;
                end
            end
            ST_ADD: begin
                ldr_d = 1'b1;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, counters and output strobes; reset lands in the IDLE decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            term_q  <= {TW{1'b0}};
            step_q  <= {SW{1'b0}};
            count_q <= TERMS_W;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zx_q    <= 1'b1;
            zt_q    <= 1'b1;
            zr_q    <= 1'b1;
            ldx_q   <= 1'b0;
            initt_q <= 1'b0;
            initr_q <= 1'b0;
            ldt_q   <= 1'b0;
            ldr_q   <= 1'b0;
            s_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            term_q  <= term_d;
            step_q  <= step_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            zx_q    <= zx_d;
            zt_q    <= zt_d;
            zr_q    <= zr_d;
            ldx_q   <= ldx_d;
            initt_q <= initt_d;
            initr_q <= initr_d;
            ldt_q   <= ldt_d;
            ldr_q   <= ldr_d;
            s_q     <= s_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign zx       = zx_q;
    assign zt       = zt_q;
    assign zr       = zr_q;
    assign ldx      = ldx_q;
    assign initt    = initt_q;
    assign initr    = initr_q;
    assign ldt      = ldt_q;
    assign ldr      = ldr_q;
    assign s        = s_q;
    assign term_idx = term_q;
    assign step_idx = step_q;

endmodule

// File: tb/tb_term_seq_controller.sv
// Directed bench for term_seq_controller with default parameters
// (MULT_STEPS=4, S_SPLIT=2, TERMS=8).
`timescale 1ns/1ps
module tb_term_seq_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] nterms = 4'd8;
    logic       busy, done, zx, zt, zr, ldx, initt, initr, ldt, ldr, s;
    logic [3:0] term_idx;
    logic [2:0] step_idx;

    int checks = 0;
    int errors = 0;

    term_seq_controller dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .nterms(nterms),
        .busy(busy), .done(done), .zx(zx), .zt(zt), .zr(zr), .ldx(ldx),
        .initt(initt), .initr(initr), .ldt(ldt), .ldr(ldr), .s(s),
        .term_idx(term_idx), .step_idx(step_idx)
    );

    always #5 clk = ~clk;

    // Runs one transaction and records what the bus did; scenarios judge the results.
    task automatic run_measure(input int hold, input logic [3:0] n,
                               output int lat, output int ldx_n, output int init_n,
                               output int ldt_n, output int ldr_n, output int pat_err,
                               output int excl_err, output int tail_bad);
        int k;
        int grp;
        lat = -1; ldx_n = 0; init_n = 0; ldt_n = 0; ldr_n = 0;
        pat_err = 0; excl_err = 0; tail_bad = 0; k = 0;
        @(negedge clk); nterms = n; start = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (ldx === 1'b1) ldx_n++;
        end
        @(negedge clk); start = 1'b0;
        for (int t = 1; t <= 400; t++) begin
            @(posedge clk); #1;
            grp = 0;
            if (ldx === 1'b1) begin ldx_n++; grp++; end
            if ((initt === 1'b1) || (initr === 1'b1)) begin init_n++; grp++; end
            if (initt !== initr) excl_err++;
            if (ldt === 1'b1) begin ldt_n++; grp++; end
            if (ldr === 1'b1) begin ldr_n++; grp++; end
            if (done === 1'b1) grp++;
            if (grp > 1) excl_err++;
            if (((zx | zt | zr) !== 1'b0) || (busy !== 1'b1 && done !== 1'b1 && t < 2)) excl_err++;
            if (ldt === 1'b1) begin
                if (s !== (k >= 2)) pat_err++;
                if (step_idx !== k[2:0]) pat_err++;
                k = (k == 3) ? 0 : k + 1;
            end else begin
                if (s !== 1'b0) pat_err++;
            end
            if (done === 1'b1) begin
                lat = t;
                break;
            end
        end
        @(posedge clk); #1;
        if ((done !== 1'b0) || (busy !== 1'b0) || ({zx, zt, zr} !== 3'b111)) tail_bad = 1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({busy, zx, zt, zr, ldx, initt, initr, ldt, ldr, s, done} !== 11'b01110000000) begin
                errors++;
                $display("FAIL reset_outputs: got %b want 01110000000",
                         {busy, zx, zt, zr, ldx, initt, initr, ldt, ldr, s, done});
            end
            checks++;
            if ({term_idx, step_idx} !== 7'd0) begin
                errors++;
                $display("FAIL reset_counters: got term=%0d step=%0d want 0/0", term_idx, step_idx);
            end
        end
        @(negedge clk); rst = 1'b0; start = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ((busy !== 1'b0) || (zx !== 1'b1)) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b zx=%b want 0/1", busy, zx);
        end
    endtask

    task automatic test_full_run;
        int lat, ldx_n, init_n, ldt_n, ldr_n, pat_err, excl_err, tail_bad;
        run_measure(3, 4'd8, lat, ldx_n, init_n, ldt_n, ldr_n, pat_err, excl_err, tail_bad);
        checks++; if (ldx_n != 3) begin errors++; $display("FAIL full_ldx: got %0d want 3", ldx_n); end
        checks++; if (init_n != 1) begin errors++; $display("FAIL full_init: got %0d want 1", init_n); end
        checks++; if (lat != 42) begin errors++; $display("FAIL full_latency: got %0d want 42", lat); end
        checks++; if (ldr_n != 8) begin errors++; $display("FAIL full_ldr: got %0d want 8", ldr_n); end
        checks++; if (ldt_n != 32) begin errors++; $display("FAIL full_ldt: got %0d want 32", ldt_n); end
        checks++; if (pat_err != 0) begin errors++; $display("FAIL full_s_pattern: got %0d errs want 0", pat_err); end
        checks++; if (excl_err != 0) begin errors++; $display("FAIL full_exclusive: got %0d errs want 0", excl_err); end
        checks++; if (tail_bad != 0) begin errors++; $display("FAIL full_single_done: got %0d want 0", tail_bad); end
        checks++;
        if ((term_idx !== 4'd7) || (step_idx !== 3'd0)) begin
            errors++;
            $display("FAIL full_idx_hold: got term=%0d step=%0d want 7/0", term_idx, step_idx);
        end
    endtask

    task automatic test_nterms_bounds;
        int lat, ldx_n, init_n, ldt_n, ldr_n, pat_err, excl_err, tail_bad;
        run_measure(1, 4'd0, lat, ldx_n, init_n, ldt_n, ldr_n, pat_err, excl_err, tail_bad);
        checks++; if (lat != 42) begin errors++; $display("FAIL zero_latency: got %0d want 42", lat); end
        checks++; if (ldr_n != 8) begin errors++; $display("FAIL zero_ldr: got %0d want 8", ldr_n); end
        run_measure(1, 4'd12, lat, ldx_n, init_n, ldt_n, ldr_n, pat_err, excl_err, tail_bad);
        checks++; if (lat != 42) begin errors++; $display("FAIL clamp_latency: got %0d want 42", lat); end
        run_measure(1, 4'd1, lat, ldx_n, init_n, ldt_n, ldr_n, pat_err, excl_err, tail_bad);
        checks++; if (lat != 7) begin errors++; $display("FAIL one_latency: got %0d want 7", lat); end
        checks++; if (ldr_n != 1) begin errors++; $display("FAIL one_ldr: got %0d want 1", ldr_n); end
        checks++; if (ldt_n != 4) begin errors++; $display("FAIL one_ldt: got %0d want 4", ldt_n); end
        checks++; if (pat_err != 0) begin errors++; $display("FAIL one_s_pattern: got %0d want 0", pat_err); end
        checks++; if (ldx_n != 1) begin errors++; $display("FAIL one_ldx: got %0d want 1", ldx_n); end
    endtask

    task automatic test_abort_idle;
        @(negedge clk); abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ((ldx !== 1'b1) || (busy !== 1'b1)) begin
            errors++;
            $display("FAIL abort_idle_ignored: got ldx=%b busy=%b want 1/1", ldx, busy);
        end
        @(posedge clk); #1;
        checks++;
        if ((busy !== 1'b0) || (ldx !== 1'b0) || (zx !== 1'b1)) begin
            errors++;
            $display("FAIL abort_load: got busy=%b ldx=%b zx=%b want 0/0/1", busy, ldx, zx);
        end
        @(negedge clk); abort = 1'b0; start = 1'b0;
    endtask

    task automatic test_abort;
        int adds;
        int bad;
        adds = 0; bad = 0;
        @(negedge clk); nterms = 4'd8; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk); #1;
            if (ldr === 1'b1) adds++;
            if (adds == 3) break;
        end
        checks++;
        if (adds != 3) begin errors++; $display("FAIL abort_reach_add: got %0d want 3", adds); end
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, ldr, ldt, done, zx, zt, zr} !== 7'b0000111) begin
            errors++;
            $display("FAIL abort_to_idle: got %b want 0000111", {busy, ldr, ldt, done, zx, zt, zr});
        end
        checks++;
        if (term_idx !== 4'd2) begin errors++; $display("FAIL abort_term_hold: got %0d want 2", term_idx); end
        @(negedge clk); abort = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(posedge clk); #1;
            if ((done !== 1'b0) || (busy !== 1'b0)) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL abort_no_done: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_reset_mid_run;
        int lat, ldx_n, init_n, ldt_n, ldr_n, pat_err, excl_err, tail_bad;
        int mults;
        int bad;
        mults = 0; bad = 0;
        @(negedge clk); nterms = 4'd8; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk); #1;
            if (ldt === 1'b1) mults++;
            if (mults == 6) break;
        end
        @(negedge clk); rst = 1'b1; abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, ldx, ldt, done, zx, term_idx, step_idx} !== {5'b00001, 4'd0, 3'd0}) begin
            errors++;
            $display("FAIL rst_mid_run: got busy=%b ldx=%b ldt=%b done=%b zx=%b term=%0d step=%0d want 0/0/0/0/1/0/0",
                     busy, ldx, ldt, done, zx, term_idx, step_idx);
        end
        @(negedge clk); rst = 1'b0; abort = 1'b0; start = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            if ((done !== 1'b0) || (busy !== 1'b0)) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rst_quiet: got %0d bad cycles want 0", bad); end
        run_measure(1, 4'd3, lat, ldx_n, init_n, ldt_n, ldr_n, pat_err, excl_err, tail_bad);
        checks++; if (lat != 17) begin errors++; $display("FAIL rst_rerun_latency: got %0d want 17", lat); end
        checks++; if (ldr_n != 3) begin errors++; $display("FAIL rst_rerun_ldr: got %0d want 3", ldr_n); end
    endtask

    task automatic test_back_to_back;
        int lat;
        int adds;
        lat = -1; adds = 0;
        @(negedge clk); nterms = 4'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int t = 1; t <= 100; t++) begin
            @(posedge clk); #1;
            if (ldr === 1'b1) adds++;
            if (t == 3) begin
                @(negedge clk); nterms = 4'd1; start = 1'b1;
            end else if (t == 4) begin
                @(negedge clk); start = 1'b0;
            end
            if (done === 1'b1) begin lat = t; break; end
        end
        checks++; if (lat != 12) begin errors++; $display("FAIL ignore_latency: got %0d want 12", lat); end
        checks++; if (adds != 2) begin errors++; $display("FAIL ignore_ldr: got %0d want 2", adds); end
        @(posedge clk); #1;
        checks++;
        if ((busy !== 1'b0) || (ldx !== 1'b0)) begin
            errors++;
            $display("FAIL ignore_back_idle: got busy=%b ldx=%b want 0/0", busy, ldx);
        end
    endtask

    initial begin
        test_reset;
        test_full_run;
        test_nterms_bounds;
        test_abort_idle;
        test_abort;
        test_reset_mid_run;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/term_seq_controller.md
TERM_SEQ_CONTROLLER -- requirements
Module: term_seq_controller

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- MULT_STEPS, 4, multiply cycles per term (>=1)
- S_SPLIT, 2, first step index with s=1 (0..MULT_STEPS)
- TERMS, 8, maximum term count (>=1)
- TW, $clog2(TERMS+1), term width
- SW, $clog2(MULT_STEPS+1), step width
REQ-002 The block SHALL have these ports (name direction width meaning):
- clk in 1 clock, rising edge
- rst in 1 synchronous active-high reset
- start in 1 request; held while operand loads
- abort in 1 cancel current run
- nterms in TW requested term count, sampled in BEGIN
- busy out 1 high in every state except IDLE
- done out 1 one-cycle completion pulse
- zx, zt, zr out 1 clear X, T, R datapath registers
- ldx out 1 load X
- initt, initr out 1 preset T and R
- ldt out 1 load T (multiply step)
- ldr out 1 load R (accumulate)
- s out 1 multiplier operand select
- term_idx out TW current term number
- step_idx out SW current multiply step
REQ-003 One clock, clk; reset rst is synchronous and active-high.

Function
REQ-004 The FSM SHALL have states IDLE, LOAD, BEGIN, MULT, ADD, DONE; all control outputs SHALL be Moore, decoded from state and counters only.
REQ-005 IDLE: zx=zt=zr=1; start=1 -> LOAD, else stay.
REQ-006 LOAD: ldx=1; start=1 -> stay; start=0 -> BEGIN.
REQ-007 BEGIN: initt=initr=1; latch nterms (0 or >TERMS -> TERMS); term_idx<=0, step_idx<=0; -> MULT.
REQ-008 MULT: ldt=1; s=1 iff step_idx>=S_SPLIT; step_idx increments each cycle; at step_idx==MULT_STEPS-1 -> ADD with step_idx<=0.
REQ-009 ADD: ldr=1; if term_idx==latched count-1 -> DONE, else term_idx increments and -> MULT.
REQ-010 DONE: done=1 for exactly one cycle; -> IDLE.
REQ-011 Run latency from first cycle with start=0 in LOAD to done SHALL be 1+N*(MULT_STEPS+1) cycles (N = latched count); done asserts on the following cycle.
REQ-012 abort=1 in any non-IDLE state SHALL force IDLE next cycle with no done pulse; abort has priority over all other transitions; abort in IDLE is ignored.
REQ-013 start asserted outside IDLE/LOAD SHALL be ignored; a new run needs return to IDLE.
REQ-014 At most one of {ldx, initt/initr, ldt, ldr, done} groups SHALL be active in any cycle; zero strobes only in IDLE.
REQ-015 term_idx and step_idx SHALL hold their values in IDLE and DONE, cleared only in BEGIN or reset.
REQ-016 nterms changes after BEGIN SHALL not affect the current run.

Reset
REQ-017 rst=1 at a rising edge SHALL force IDLE, term_idx=0, step_idx=0, regardless of state; during and after reset outputs equal IDLE decode (zx=zt=zr=1, all others 0, busy=0).
REQ-018 rst SHALL override abort and start in the same cycle.

Verification
REQ-019 Defaults, nterms=8, start high 3 cycles then low -> ldx high 3 cycles, BEGIN 1 cycle, 40 cycles MULT/ADD, done pulse 42 cycles after start falls; ldr pulses=8.
REQ-020 MULT_STEPS=4, S_SPLIT=2 -> per term s pattern 0,0,1,1 with ldt=1 on all 4, step_idx 0..3.
REQ-021 nterms=0 -> run uses TERMS=8; nterms=1 -> single term, done 7 cycles after start falls.
REQ-022 abort at 3rd ADD -> IDLE next cycle, busy=0, done never asserts, zero strobes asserted.
REQ-023 rst mid-MULT with abort=1 and start=1 -> IDLE, term_idx=0, step_idx=0, no done; later start runs normally.
